// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package if_pkg;
  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [WORD_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [WORD_W-1:0] PC_STEP_DEF   = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] a);
    return a & ~32'h3;
  endfunction
endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory fetch bus: request/address out, ready/data back.
interface if_fetch_ctrl_if;
  import if_pkg::*;

  logic              imem_req;
  logic [WORD_W-1:0] imem_addr;
  logic              imem_ready;
  logic [WORD_W-1:0] imem_data;

  modport master (output imem_req, imem_addr, input imem_ready, imem_data);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_data);
endinterface

// File: rtl/if_skid_buf.sv
// One-entry {npc, ir} holding buffer for an instruction fetched during a stall.
module if_skid_buf
  import if_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic              unload_i,
  input  logic [WORD_W-1:0] npc_i,
  input  logic [WORD_W-1:0] ir_i,
  output logic [WORD_W-1:0] npc_o,
  output logic [WORD_W-1:0] ir_o,
  output logic              full_o
);
  logic              full_q;
  logic [WORD_W-1:0] npc_q, ir_q;

  // Clear and unload win over load; the controller never asserts them together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      npc_q  <= '0;
      ir_q   <= '0;
    end else if (clear_i || unload_i) begin
      full_q <= 1'b0;
    end else if (load_i) begin
      full_q <= 1'b1;
      npc_q  <= npc_i;
      ir_q   <= ir_i;
    end
  end

  assign npc_o  = npc_q;
  assign ir_o   = ir_q;
  assign full_o = full_q;
endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage sequencer: owns PC, handshakes with imem, drives IF/ID.
module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [WORD_W-1:0] PC_STEP   = PC_STEP_DEF,
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              branch_taken_i,
  input  logic [WORD_W-1:0] branch_target_i,
  if_fetch_ctrl_if.master   imem,
  output logic [WORD_W-1:0] ifid_npc_o,
  output logic [WORD_W-1:0] ifid_ir_o,
  output logic              ifid_valid_o
);
  fetch_state_e      state_q;
  logic [WORD_W-1:0] pc_q, pc_inc;
  logic [WORD_W-1:0] ifid_npc_q, ifid_ir_q;
  logic              ifid_valid_q;

  logic              skid_load, skid_unload, skid_full;
  logic [WORD_W-1:0] skid_npc, skid_ir;

  assign pc_inc = pc_q + PC_STEP;

  assign skid_load   = (state_q == FETCH) && !branch_taken_i && imem.imem_ready && stall_i;
  assign skid_unload = (state_q == HOLD)  && !branch_taken_i && !stall_i;

  if_skid_buf u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (skid_load),
    .clear_i  (branch_taken_i),
    .unload_i (skid_unload),
    .npc_i    (pc_inc),
    .ir_i     (imem.imem_data),
    .npc_o    (skid_npc),
    .ir_o     (skid_ir),
    .full_o   (skid_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      ifid_npc_q   <= '0;
      ifid_ir_q    <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else if (branch_taken_i) begin
      // Redirect beats stall and discards any data returned this cycle.
      state_q      <= FETCH;
      pc_q         <= align_word(branch_target_i);
      ifid_ir_q    <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: state_q <= FETCH;
        FETCH: begin
          if (imem.imem_ready) begin
            pc_q <= pc_inc;
            if (stall_i) begin
              state_q <= HOLD;
            end else begin
              ifid_npc_q   <= pc_inc;
              ifid_ir_q    <= imem.imem_data;
              ifid_valid_q <= 1'b1;
            end
          end else if (!stall_i) begin
            ifid_ir_q    <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall_i) begin
            state_q      <= FETCH;
            ifid_npc_q   <= skid_npc;
            ifid_ir_q    <= skid_ir;
            ifid_valid_q <= skid_full;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem.imem_req  = (state_q == FETCH);
  assign imem.imem_addr = pc_q;
  assign ifid_npc_o     = ifid_npc_q;
  assign ifid_ir_o      = ifid_ir_q;
  assign ifid_valid_o   = ifid_valid_q;
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed vector table, corner sequences, random vs. model.
module tb_if_fetch_ctrl;
  import if_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic [31:0] tgt = '0;
  logic [31:0] ifid_npc, ifid_ir;
  logic        ifid_valid;

  always #5 clk = ~clk;

  if_fetch_ctrl_if bus();

  if_fetch_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall),
    .branch_taken_i  (br),
    .branch_target_i (tgt),
    .imem            (bus.master),
    .ifid_npc_o      (ifid_npc),
    .ifid_ir_o       (ifid_ir),
    .ifid_valid_o    (ifid_valid)
  );

  function automatic logic [31:0] memw(input logic [31:0] a);
    case (a)
      32'h0:   return 32'hA000_00AA;
      32'h4:   return 32'h1000_0011;
      32'h8:   return 32'h2000_0022;
      32'h24:  return 32'h9000_0099;
      default: return a ^ 32'hC0DE_0000;
    endcase
  endfunction

  assign bus.imem_data = memw(bus.imem_addr);

  // Observed bundle: {req, addr, valid, ir, npc}
  wire [97:0] obs = {bus.imem_req, bus.imem_addr, ifid_valid, ifid_ir, ifid_npc};

  function automatic logic [97:0] ex(input logic rq, input logic [31:0] ad,
                                     input logic v, input logic [31:0] ir, input logic [31:0] npc);
    return {rq, ad, v, ir, npc};
  endfunction

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [97:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got req/addr/v/ir/npc=%h want %h", nm, obs, exp);
  endtask

  task automatic cyc(input logic s, input logic b, input logic r, input logic [31:0] t);
    stall = s; br = b; bus.imem_ready = r; tgt = t;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        s, b, r;
    logic [31:0] t;
    logic [97:0] exp;
  } vec_t;

  vec_t tv[17];

  // Reference model: a pending-instruction queue instead of an explicit hold state.
  typedef struct { logic [31:0] npc, ir; } ent_t;
  ent_t        m_q[$];
  logic        m_started, m_v;
  logic [31:0] m_pc, m_ir, m_npc;

  task automatic m_reset();
    m_q.delete();
    m_started = 0; m_pc = 32'h0; m_v = 0; m_ir = 32'h0; m_npc = 32'h0;
  endtask

  task automatic m_step(input logic s, input logic b, input logic r, input logic [31:0] t);
    ent_t e;
    if (b) begin
      m_started = 1;
      m_pc = {t[31:2], 2'b00};
      m_v = 0; m_ir = 32'h0;
      m_q.delete();
    end else if (!m_started) begin
      m_started = 1;
    end else if (m_q.size() > 0) begin
      if (!s) begin
        e = m_q.pop_front();
        m_v = 1; m_ir = e.ir; m_npc = e.npc;
      end
    end else if (r) begin
      e.npc = m_pc + 32'd4;
      e.ir  = memw(m_pc);
      if (s) m_q.push_back(e);
      else begin m_v = 1; m_ir = e.ir; m_npc = e.npc; end
      m_pc = m_pc + 32'd4;
    end else if (!s) begin
      m_v = 0; m_ir = 32'h0;
    end
  endtask

  function automatic logic [97:0] m_obs();
    return {m_started && (m_q.size() == 0), m_pc, m_v, m_ir, m_npc};
  endfunction

  initial begin
    logic s, b, r;
    logic [31:0] t;

    tv[0]  = '{0,0,1, 32'h0,        ex(1, 32'h0,  0, 32'h0, 32'h0)};
    tv[1]  = '{0,0,1, 32'h0,        ex(1, 32'h4,  1, 32'hA00000AA, 32'h4)};
    tv[2]  = '{0,0,0, 32'h0,        ex(1, 32'h4,  0, 32'h0, 32'h4)};
    tv[3]  = '{0,0,0, 32'h0,        ex(1, 32'h4,  0, 32'h0, 32'h4)};
    tv[4]  = '{0,0,1, 32'h0,        ex(1, 32'h8,  1, 32'h10000011, 32'h8)};
    tv[5]  = '{1,0,1, 32'h0,        ex(0, 32'hC,  1, 32'h10000011, 32'h8)};
    tv[6]  = '{1,0,1, 32'h0,        ex(0, 32'hC,  1, 32'h10000011, 32'h8)};
    tv[7]  = '{1,0,1, 32'h0,        ex(0, 32'hC,  1, 32'h10000011, 32'h8)};
    tv[8]  = '{0,0,1, 32'h0,        ex(1, 32'hC,  1, 32'h20000022, 32'hC)};
    tv[9]  = '{0,0,1, 32'h0,        ex(1, 32'h10, 1, 32'hC0DE000C, 32'h10)};
    tv[10] = '{1,0,1, 32'h0,        ex(0, 32'h14, 1, 32'hC0DE000C, 32'h10)};
    tv[11] = '{1,1,1, 32'h26,       ex(1, 32'h24, 0, 32'h0, 32'h10)};
    tv[12] = '{0,0,1, 32'h0,        ex(1, 32'h28, 1, 32'h90000099, 32'h28)};
    tv[13] = '{0,1,1, 32'hFFFFFFFE, ex(1, 32'hFFFFFFFC, 0, 32'h0, 32'h28)};
    tv[14] = '{0,0,1, 32'h0,        ex(1, 32'h0,  1, 32'h3F21FFFC, 32'h0)};
    tv[15] = '{1,1,1, 32'h8,        ex(1, 32'h8,  0, 32'h0, 32'h0)};
    tv[16] = '{1,0,0, 32'h0,        ex(1, 32'h8,  0, 32'h0, 32'h0)};

    bus.imem_ready = 1'b1;
    #12;
    chk("reset_state", ex(0, 32'h0, 0, 32'h0, 32'h0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (tv[i]) begin
      cyc(tv[i].s, tv[i].b, tv[i].r, tv[i].t);
      chk($sformatf("vec%0d", i), tv[i].exp);
    end

    // Async reset while holding a skid entry.
    cyc(1, 0, 1, 32'h0);
    chk("hold_with_bubble", ex(0, 32'hC, 0, 32'h0, 32'h0));
    #2 rst_n = 1'b0;
    #1 chk("async_reset_mid_hold", ex(0, 32'h0, 0, 32'h0, 32'h0));
    #2 rst_n = 1'b1;
    cyc(0, 0, 1, 32'h0);
    chk("restart_fetch", ex(1, 32'h0, 0, 32'h0, 32'h0));
    cyc(0, 0, 1, 32'h0);
    chk("restart_first_instr", ex(1, 32'h4, 1, 32'hA00000AA, 32'h4));

    // Redirect while still idle.
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    cyc(0, 1, 1, 32'h24);
    chk("redirect_in_idle", ex(1, 32'h24, 0, 32'h0, 32'h0));
    cyc(0, 0, 1, 32'h0);
    chk("redirect_idle_instr", ex(1, 32'h28, 1, 32'h90000099, 32'h28));

    // Random traffic against the model.
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    m_reset();
    for (int k = 0; k < 1500; k++) begin
      s = ($urandom_range(2) == 0);
      b = ($urandom_range(9) == 0);
      r = ($urandom_range(2) != 0);
      t = ($urandom_range(3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(15))) : 32'($urandom_range(255));
      m_step(s, b, r, t);
      cyc(s, b, r, t);
      chk($sformatf("rand%0d", k), m_obs());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
